yakbd_keydec: RTL and testbench

- Stateful PS/2 Set-2 key-event decoder for the yakbd driver.
- Consumes raw scan bytes from the PS/2 receiver and tracks the make/break, E0-extended and E1-pause prefixes.
- Maintains the Shift, Ctrl and CapsLock modifier state and translates make events into ASCII/control bytes.
- Buffers results in a parametrised FIFO with a valid/ready interface towards the CPU-side MMIO.

---
 rtl/yakbd_pkg.sv | 30 +++
 rtl/yakbd_scan_lut.sv | 54 +++++
 rtl/yakbd_keydec.sv | 140 ++++++++++++++
 tb/tb_yakbd_keydec.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/yakbd_pkg.sv
// yakbd_pkg: Set-2 scan-code constants, emitted control codes and prefix-decoder states.
package yakbd_pkg;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] KC_UP     = 8'h11;
    localparam logic [7:0] KC_DOWN   = 8'h12;
    localparam logic [7:0] KC_LEFT   = 8'h13;
    localparam logic [7:0] KC_RIGHT  = 8'h14;
    localparam logic [7:0] KC_BS     = 8'h08;
    localparam logic [7:0] KC_LF     = 8'h0A;
    localparam logic [7:0] KC_TAB    = 8'h09;
    localparam logic [7:0] KC_ESC    = 8'h1B;
    localparam logic [7:0] KC_SPACE  = 8'h20;
    // E1 is followed by seven more bytes that carry no key events
    localparam logic [2:0] PAUSE_LEN = 3'd7;
    typedef enum logic [2:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK, ST_PAUSE} state_t;
    function automatic logic is_modifier(input logic [7:0] code, input logic ext);
        return ext ? (code == SC_CTRL)
                   : (code == SC_LSHIFT || code == SC_RSHIFT || code == SC_CTRL || code == SC_CAPS);
    endfunction
endpackage

// File: rtl/yakbd_scan_lut.sv
// yakbd_scan_lut: combinational Set-2 make-code to ASCII/control-byte translation.
module yakbd_scan_lut
  import yakbd_pkg::*;
(
  input  logic [7:0] code_i,
  input  logic       ext_i,
  input  logic       shift_i,
  input  logic       caps_i,
  input  logic       ctrl_i,
  output logic [7:0] char_o,
  output logic       hit_o
);
  logic [7:0] lo, hi, arrow;
  logic       letter;
  always_comb begin
    {lo, hi} = 16'h0000;
    case (code_i)
      8'h1C: {lo, hi} = "aA";  8'h32: {lo, hi} = "bB";  8'h21: {lo, hi} = "cC";
      8'h23: {lo, hi} = "dD";  8'h24: {lo, hi} = "eE";  8'h2B: {lo, hi} = "fF";
      8'h34: {lo, hi} = "gG";  8'h33: {lo, hi} = "hH";  8'h43: {lo, hi} = "iI";
      8'h3B: {lo, hi} = "jJ";  8'h42: {lo, hi} = "kK";  8'h4B: {lo, hi} = "lL";
      8'h3A: {lo, hi} = "mM";  8'h31: {lo, hi} = "nN";  8'h44: {lo, hi} = "oO";
      8'h4D: {lo, hi} = "pP";  8'h15: {lo, hi} = "qQ";  8'h2D: {lo, hi} = "rR";
      8'h1B: {lo, hi} = "sS";  8'h2C: {lo, hi} = "tT";  8'h3C: {lo, hi} = "uU";
      8'h2A: {lo, hi} = "vV";  8'h1D: {lo, hi} = "wW";  8'h22: {lo, hi} = "xX";
      8'h35: {lo, hi} = "yY";  8'h1A: {lo, hi} = "zZ";
      8'h16: {lo, hi} = "1!";  8'h1E: {lo, hi} = "2@";  8'h26: {lo, hi} = "3#";
      8'h25: {lo, hi} = "4$";  8'h2E: {lo, hi} = "5%";  8'h36: {lo, hi} = "6^";
      8'h3D: {lo, hi} = "7&";  8'h3E: {lo, hi} = "8*";  8'h46: {lo, hi} = "9(";
      8'h45: {lo, hi} = "0)";  8'h0E: {lo, hi} = "`~";  8'h4E: {lo, hi} = "-_";
      8'h55: {lo, hi} = "=+";  8'h54: {lo, hi} = "[{";  8'h5B: {lo, hi} = "]}";
      8'h5D: {lo, hi} = {8'h5C, "|"};
      8'h4C: {lo, hi} = ";:";
      8'h52: {lo, hi} = {"'", 8'h22};
      8'h41: {lo, hi} = ",<";  8'h49: {lo, hi} = ".>";  8'h4A: {lo, hi} = "/?";
      8'h29: {lo, hi} = {KC_SPACE, KC_SPACE};
      8'h66: {lo, hi} = {KC_BS, KC_BS};
      8'h5A: {lo, hi} = {KC_LF, KC_LF};
      8'h0D: {lo, hi} = {KC_TAB, KC_TAB};
      8'h76: {lo, hi} = {KC_ESC, KC_ESC};
      default: {lo, hi} = 16'h0000;
    endcase
  end
  assign arrow  = (code_i == SC_UP)    ? KC_UP
                : (code_i == SC_DOWN)  ? KC_DOWN
                : (code_i == SC_LEFT)  ? KC_LEFT
                : (code_i == SC_RIGHT) ? KC_RIGHT : 8'h00;
  assign letter = lo >= "a" && lo <= "z";
  assign char_o = ext_i              ? arrow
                : !letter            ? (shift_i ? hi : lo)
                : ctrl_i             ? (hi & 8'h1F)
                : (shift_i ^ caps_i) ? hi : lo;
  assign hit_o  = ext_i ? (arrow != 8'h00) : (lo != 8'h00);
endmodule

// File: rtl/yakbd_keydec.sv
// yakbd_keydec: PS/2 Set-2 prefix decoder with modifier tracking, ASCII translation
// and a first-word fall-through output FIFO.
module yakbd_keydec
    import yakbd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int CTRL_MAP    = 1,
    parameter int EMIT_ARROWS = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          scan_valid,
    input  logic [7:0]                    scan_code,
    output logic                          ascii_valid,
    output logic [7:0]                    ascii_data,
    input  logic                          ascii_ready,
    output logic                          shift_o,
    output logic                          ctrl_o,
    output logic                          caps_o,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    state_t        state_q, state_d;
    logic [2:0]    pcnt_q, pcnt_d;
    logic          make, brk, ext, key_ev, caps_ev;
    logic          lshift_q, lshift_d, rshift_q, rshift_d, lctrl_q, lctrl_d, rctrl_q, rctrl_d;
    logic          caps_q, caps_d, caps_rel_q, caps_rel_d;
    logic [7:0]    lut_char, char_q;
    logic          lut_hit, push_q, push_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   lvl_q;
    logic          ovf_q, pop, full, wr;
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        make    = 1'b0;
        brk     = 1'b0;
        ext     = 1'b0;
        if (scan_valid) begin
            case (state_q)
                ST_IDLE:
                    if (scan_code == SC_BREAK) state_d = ST_BRK;
                    else if (scan_code == SC_EXT) state_d = ST_EXT;
                    else if (scan_code == SC_PAUSE) begin
                        state_d = ST_PAUSE;
                        pcnt_d  = PAUSE_LEN;
                    end else make = 1'b1;
                ST_BRK: begin
                    brk     = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_EXT: begin
                    ext = 1'b1;
                    if (scan_code == SC_BREAK) state_d = ST_EXT_BRK;
                    else begin
                        make    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    brk     = 1'b1;
                    ext     = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_PAUSE: begin
                    pcnt_d  = pcnt_q - 3'd1;
                    state_d = (pcnt_q == 3'd1) ? ST_IDLE : ST_PAUSE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end
    assign key_ev     = make | brk;
    assign lshift_d   = (key_ev && !ext && scan_code == SC_LSHIFT) ? make : lshift_q;
    assign rshift_d   = (key_ev && !ext && scan_code == SC_RSHIFT) ? make : rshift_q;
    assign lctrl_d    = (key_ev && !ext && scan_code == SC_CTRL) ? make : lctrl_q;
    assign rctrl_d    = (key_ev && ext && scan_code == SC_CTRL) ? make : rctrl_q;
    // caps_rel remembers whether the last CapsLock event was a release, so held repeats do not toggle
    assign caps_ev    = key_ev && !ext && scan_code == SC_CAPS;
    assign caps_d     = caps_q ^ (caps_ev && make && caps_rel_q);
    assign caps_rel_d = caps_ev ? brk : caps_rel_q;
    assign shift_o    = lshift_q | rshift_q;
    assign ctrl_o     = lctrl_q | rctrl_q;
    assign caps_o     = caps_q;
    yakbd_scan_lut u_lut (
        .code_i  (scan_code),
        .ext_i   (ext),
        .shift_i (shift_o),
        .caps_i  (caps_q),
        .ctrl_i  (ctrl_o && (CTRL_MAP != 0)),
        .char_o  (lut_char),
        .hit_o   (lut_hit)
    );
    assign push_d      = make && !is_modifier(scan_code, ext) && lut_hit && (!ext || EMIT_ARROWS != 0);
    assign pop         = ascii_valid && ascii_ready;
    assign full        = lvl_q == (AW+1)'(FIFO_DEPTH);
    assign wr          = push_q && (!full || pop);
    assign ascii_valid = lvl_q != '0;
    assign ascii_data  = ascii_valid ? mem_q[rp_q] : 8'h00;
    assign fifo_level  = lvl_q;
    assign overflow    = ovf_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pcnt_q     <= '0;
            lshift_q   <= 1'b0;
            rshift_q   <= 1'b0;
            lctrl_q    <= 1'b0;
            rctrl_q    <= 1'b0;
            caps_q     <= 1'b0;
            caps_rel_q <= 1'b1;
            push_q     <= 1'b0;
            char_q     <= 8'h00;
            wp_q       <= '0;
            rp_q       <= '0;
            lvl_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            lshift_q   <= lshift_d;
            rshift_q   <= rshift_d;
            lctrl_q    <= lctrl_d;
            rctrl_q    <= rctrl_d;
            caps_q     <= caps_d;
            caps_rel_q <= caps_rel_d;
            push_q     <= push_d;
            char_q     <= lut_char;
            if (wr) wp_q <= wp_q + 1'b1;
            if (pop) rp_q <= rp_q + 1'b1;
            lvl_q      <= lvl_q + (AW+1)'(wr) - (AW+1)'(pop);
            if (push_q && full && !pop) ovf_q <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q] <= char_q;
    end
endmodule

// File: tb/tb_yakbd_keydec.sv
// tb_yakbd_keydec: directed and randomized scan-byte streams checked against a behavioural keyboard model.
module tb_yakbd_keydec;
  typedef logic [7:0] u8;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1, scan_valid = 1'b0, ascii_ready = 1'b0;
  u8    scan_code = 8'h00;
  logic ascii_valid, shift_o, ctrl_o, caps_o, overflow;
  u8    ascii_data;
  logic [2:0] fifo_level;
  int   checks = 0, failures = 0;

  yakbd_keydec #(.FIFO_DEPTH(DEPTH), .CTRL_MAP(1), .EMIT_ARROWS(1)) dut (
    .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_code(scan_code),
    .ascii_valid(ascii_valid), .ascii_data(ascii_data), .ascii_ready(ascii_ready),
    .shift_o(shift_o), .ctrl_o(ctrl_o), .caps_o(caps_o), .overflow(overflow),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  u8 let_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                       8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                       8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  u8 sym_codes[21] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45,
                       8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
  u8 fix_codes[5]  = '{8'h29, 8'h66, 8'h5A, 8'h0D, 8'h76};
  u8 fix_vals[5]   = '{8'h20, 8'h08, 8'h0A, 8'h09, 8'h1B};
  u8 sym_lo[21]    = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h30,
                       8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
  u8 sym_hi[21]    = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28, 8'h29,
                       8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};
  string alpha = "abcdefghijklmnopqrstuvwxyz";

  u8  lo_t[u8];
  u8  hi_t[u8];
  bit is_let[u8];
  u8  exp_q[$];
  u8  seq[$];
  bit m_ls, m_rs, m_lc, m_rc, m_caps, m_caps_rel, m_ovf, p_brk, p_ext;
  int m_pause;

  function automatic void init_tables();
    for (int i = 0; i < 26; i++) begin
      lo_t[let_codes[i]] = alpha[i];
      is_let[let_codes[i]] = 1'b1;
    end
    for (int i = 0; i < 21; i++) begin
      lo_t[sym_codes[i]] = sym_lo[i];
      hi_t[sym_codes[i]] = sym_hi[i];
    end
    for (int i = 0; i < 5; i++) begin
      lo_t[fix_codes[i]] = fix_vals[i];
      hi_t[fix_codes[i]] = fix_vals[i];
    end
  endfunction

  function automatic void model_reset();
    {m_ls, m_rs, m_lc, m_rc, m_caps, m_ovf, p_brk, p_ext} = '0;
    m_caps_rel = 1'b1;
    m_pause = 0;
    exp_q.delete();
  endfunction

  function automatic void model_byte(u8 b);
    bit isbrk, isext, sh, mod, hit;
    u8  c;
    if (m_pause > 0) begin m_pause--; return; end
    if (!p_brk && !p_ext && b == 8'hE1) begin m_pause = 7; return; end
    if (!p_brk && b == 8'hF0) begin p_brk = 1'b1; return; end
    if (!p_brk && !p_ext && b == 8'hE0) begin p_ext = 1'b1; return; end
    isbrk = p_brk;
    isext = p_ext;
    p_brk = 1'b0;
    p_ext = 1'b0;
    if (!isext) begin
      if (b == 8'h12) m_ls = !isbrk;
      if (b == 8'h59) m_rs = !isbrk;
      if (b == 8'h14) m_lc = !isbrk;
      if (b == 8'h58) begin
        if (!isbrk && m_caps_rel) m_caps = !m_caps;
        m_caps_rel = isbrk;
      end
      mod = (b == 8'h12 || b == 8'h59 || b == 8'h14 || b == 8'h58);
    end else begin
      if (b == 8'h14) m_rc = !isbrk;
      mod = (b == 8'h14);
    end
    if (isbrk || mod) return;
    sh  = m_ls || m_rs;
    hit = 1'b1;
    c   = 8'h00;
    if (isext) begin
      case (b)
        8'h75: c = 8'h11;
        8'h72: c = 8'h12;
        8'h6B: c = 8'h13;
        8'h74: c = 8'h14;
        default: hit = 1'b0;
      endcase
    end else if (is_let.exists(b)) begin
      if (m_lc || m_rc) c = (lo_t[b] - 8'h20) & 8'h1F;
      else c = (sh ^ m_caps) ? lo_t[b] - 8'h20 : lo_t[b];
    end else if (lo_t.exists(b)) c = sh ? hi_t[b] : lo_t[b];
    else hit = 1'b0;
    if (hit) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(c);
      else m_ovf = 1'b1;
    end
  endfunction

  function automatic u8 rand_byte();
    int r;
    u8 mods[4] = '{8'h12, 8'h59, 8'h14, 8'h58};
    u8 arrows[4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
    r = int'($urandom_range(0, 99));
    if (r < 40) return let_codes[$urandom_range(0, 25)];
    if (r < 55) return sym_codes[$urandom_range(0, 20)];
    if (r < 60) return fix_codes[$urandom_range(0, 4)];
    if (r < 72) return mods[$urandom_range(0, 3)];
    if (r < 84) return 8'hF0;
    if (r < 92) return 8'hE0;
    if (r < 94) return 8'hE1;
    if (r < 97) return arrows[$urandom_range(0, 3)];
    return u8'($urandom);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_mods(string tag);
    chk({tag, ":shift"}, 32'(shift_o), 32'(m_ls | m_rs));
    chk({tag, ":ctrl"}, 32'(ctrl_o), 32'(m_lc | m_rc));
    chk({tag, ":caps"}, 32'(caps_o), 32'(m_caps));
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, ":valid"}, 32'(ascii_valid), 0);
    chk({tag, ":data"}, 32'(ascii_data), 0);
    chk({tag, ":level"}, 32'(fifo_level), 0);
    chk({tag, ":overflow"}, 32'(overflow), 0);
    chk({tag, ":shift"}, 32'(shift_o), 0);
    chk({tag, ":ctrl"}, 32'(ctrl_o), 0);
    chk({tag, ":caps"}, 32'(caps_o), 0);
  endtask

  task automatic send(u8 b);
    scan_code  = b;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic send_seq(string tag);
    foreach (seq[i]) begin
      send(seq[i]);
      chk_mods(tag);
    end
  endtask

  task automatic drain(string tag);
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      for (int n = 0; n < 8 && !ascii_valid; n++) @(negedge clk);
      chk({tag, ":head"}, 32'(ascii_data), 32'(exp_q.pop_front()));
      ascii_ready = 1'b1;
      @(negedge clk);
      ascii_ready = 1'b0;
    end
    chk({tag, ":level_empty"}, 32'(fifo_level), 0);
    chk({tag, ":valid_empty"}, 32'(ascii_valid), 0);
    chk({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    scan_valid = 1'b0;
    ascii_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    init_tables();
    do_reset();
    chk_reset_state("reset");
    scan_code  = 8'h1C;
    scan_valid = 1'b1;
    @(posedge clk);
    #1 scan_valid = 1'b0;
    chk("lat_n1_valid", 32'(ascii_valid), 0);
    @(posedge clk);
    #1 chk("lat_n2_valid", 32'(ascii_valid), 1);
    model_byte(8'h1C);
    @(negedge clk);
    seq = '{8'hF0, 8'h1C};
    send_seq("a_break");
    drain("single_a");
    seq = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
    send_seq("shift");
    drain("shift");
    seq = '{8'h58, 8'h58, 8'hF0, 8'h58, 8'h58, 8'hF0, 8'h58, 8'h58, 8'hF0, 8'h58,
            8'h12, 8'h15, 8'hF0, 8'h12};
    send_seq("caps");
    drain("caps");
    seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h75, 8'hE0, 8'h14, 8'h21, 8'hE0, 8'hF0, 8'h14};
    send_seq("ext");
    drain("ext");
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h29};
    send_seq("pause");
    drain("pause");
    send(8'hF0);
    do_reset();
    seq = '{8'h1C};
    send_seq("midreset");
    drain("midreset");
    do_reset();
    seq = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
    send_seq("fill");
    repeat (2) @(negedge clk);
    chk("full_level", 32'(fifo_level), 32'(exp_q.size()));
    chk("full_overflow", 32'(overflow), 32'(m_ovf));
    chk("hold_head", 32'(ascii_data), 32'(exp_q[0]));
    @(negedge clk);
    chk("hold_head_stable", 32'(ascii_data), 32'(exp_q[0]));
    scan_code  = 8'h22;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid  = 1'b0;
    ascii_ready = 1'b1;
    @(negedge clk);
    ascii_ready = 1'b0;
    void'(exp_q.pop_front());
    model_byte(8'h22);
    chk("pushpop_level", 32'(fifo_level), 32'(exp_q.size()));
    chk("pushpop_head", 32'(ascii_data), 32'(exp_q[0]));
    drain("full");
    seq = '{8'h12, 8'h58, 8'hE0, 8'h14, 8'h1C};
    send_seq("pre_reset");
    repeat (2) @(negedge clk);
    do_reset();
    chk_reset_state("reset2");
    for (int i = 0; i < 400; i++) begin
      send(rand_byte());
      chk_mods("rand");
      if (exp_q.size() >= 3) drain("rand");
    end
    drain("rand_end");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
